// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: op encodings, FSM states and
// a sign/magnitude helper used when operands are captured.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Widest operand the helper below can handle.
    localparam int MAX_W = 128;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Returns {negative, magnitude}. v must already be sign-extended to MAX_W bits.
    function automatic logic [MAX_W:0] abs_sgn(input logic [MAX_W-1:0] v, input logic is_signed);
        logic neg;
        neg = is_signed & v[MAX_W-1];
        return {neg, neg ? (~v) + MAX_W'(1) : v};
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared 2*WIDTH shift register for radix-2 shift-add multiply and restoring
// divide on unsigned magnitudes; one step per enabled cycle.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_init,
    input  logic [WIDTH-1:0]   opnd_init,
    output logic [2*WIDTH-1:0] acc
);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     sum, rem_ext, diff;

    // Multiply: {partial, multiplier}; divide: {remainder, dividend/quotient}.
    always_comb begin
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        rem_ext = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_ext - {1'b0, opnd_q};
        if (load) begin
            acc_d  = acc_init;
            opnd_d = opnd_init;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else              acc_d = {rem_ext[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else if (acc_q[0]) begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to skip iteration when the result is trivial.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d;
    logic               is_div_q, is_div_d, res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d, div_zero_q, div_zero_d;

    logic               op_div, op_signed, early;
    logic [MAX_W:0]     a_abs_sgn, b_abs_sgn;
    logic [WIDTH-1:0]   a_mag, b_mag, dp_opnd, quo, rem;
    logic [2*WIDTH-1:0] dp_init, dp_acc, prod;
    logic               dp_load, dp_step, unused_abs;

    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);

    assign a_abs_sgn  = abs_sgn({{(MAX_W-WIDTH){a[WIDTH-1]}}, a}, op_signed);
    assign b_abs_sgn  = abs_sgn({{(MAX_W-WIDTH){b[WIDTH-1]}}, b}, op_signed);
    assign a_mag      = a_abs_sgn[WIDTH-1:0];
    assign b_mag      = b_abs_sgn[WIDTH-1:0];
    assign unused_abs = ^{a_abs_sgn[MAX_W-1:WIDTH], b_abs_sgn[MAX_W-1:WIDTH]};

`ifdef MULDIV_EARLY_OUT_EN
    assign early = op_div ? ((b != '0) && (a_mag < b_mag)) : ((a == '0) || (b == '0));
`else
    assign early = 1'b0;
`endif

    // An early-out divide preloads remainder=|a|, quotient=0 so FIX finishes it.
    always_comb begin
        if (op_div) begin
            dp_opnd = b_mag;
            dp_init = early ? {a_mag, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, a_mag};
        end else begin
            dp_opnd = a_mag;
            dp_init = early ? '0 : {{WIDTH{1'b0}}, b_mag};
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (dp_load),
        .step      (dp_step),
        .is_div    (is_div_q),
        .acc_init  (dp_init),
        .opnd_init (dp_opnd),
        .acc       (dp_acc)
    );

    assign quo  = res_neg_q ? -dp_acc[WIDTH-1:0] : dp_acc[WIDTH-1:0];
    assign rem  = rem_neg_q ? -dp_acc[2*WIDTH-1:WIDTH] : dp_acc[2*WIDTH-1:WIDTH];
    assign prod = res_neg_q ? -dp_acc : dp_acc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        a_d        = a_q;
        is_div_d   = is_div_q;
        res_neg_d  = res_neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (mthi) hi_d = wdata;
                if (mtlo) lo_d = wdata;
                if (start && !flush) begin
                    state_d    = early ? FIX : CALC;
                    cnt_d      = early ? '0 : CNT_W'(WIDTH);
                    dp_load    = 1'b1;
                    a_d        = a;
                    is_div_d   = op_div;
                    res_neg_d  = a_abs_sgn[MAX_W] ^ b_abs_sgn[MAX_W];
                    rem_neg_d  = a_abs_sgn[MAX_W];
                    div_zero_d = op_div && (b == '0);
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = FIX;
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (is_div_q) begin
                        lo_d = div_zero_q ? '1 : quo;
                        hi_d = div_zero_q ? a_q : rem;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            a_q        <= '0;
            is_div_q   <= 1'b0;
            res_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            a_q        <= a_d;
            is_div_q   <= is_div_d;
            res_neg_q  <= res_neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
